// File: rtl/mux_scan_nto1_pkg.sv
// Shared definitions for the scanning N:1 selector: FSM states, mode codes
// and the index-width helper.
package mux_scan_nto1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Ceiling log2, never less than 1 so a select bus always has at least one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_scan_nto1_comb.sv
// Purely combinational N:1 slice selector; an index at or beyond N yields zero.
module mux_nto1_comb
  import mux_scan_nto1_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned N     = 16,
  localparam int unsigned SEL_W = clog2(N)
) (
  input  logic [N*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]   idx,
  output logic [WIDTH-1:0]   dout
);

  always_comb begin
    dout = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx == SEL_W'(k)) dout = in_bus[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_scan_nto1.sv
// Registered N-channel selector: fixed channel (DIRECT) or round-robin sweep
// with programmable dwell (SCAN). All outputs are registered.
module mux_scan_nto1
  import mux_scan_nto1_pkg::*;
#(
  parameter  int unsigned WIDTH   = 8,
  parameter  int unsigned N       = 16,
  parameter  int unsigned DWELL_W = 8,
  localparam int unsigned SEL_W   = clog2(N)
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic [N*WIDTH-1:0] in_bus,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_ch,
  output logic               out_valid,
  output logic               wrap
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               scan_entry;
  logic [SEL_W-1:0]   scan_idx;
  logic [DWELL_W-1:0] scan_cnt;
  logic [SEL_W-1:0]   mux_idx;
  logic [WIDTH-1:0]   mux_data;
  logic               sel_ok;
  logic               wrap_d;

  always_comb begin
    state_d = ST_IDLE;
    if (en) begin
      if (mode == MODE_SCAN) state_d = ST_SCAN;
      else                   state_d = ST_DIRECT;
    end
  end

  // The entry edge behaves as a normal scan step starting from channel 0,
  // count 0, so dwell=0 yields one cycle per channel from the very start.
  always_comb begin
    scan_entry = (state_d == ST_SCAN) && (state_q != ST_SCAN);
    scan_idx   = scan_entry ? '0 : ch_q;
    scan_cnt   = scan_entry ? '0 : cnt_q;
    if (scan_cnt >= dwell) begin
      cnt_d = '0;
      ch_d  = (scan_idx == LAST_CH) ? '0 : scan_idx + SEL_W'(1);
    end else begin
      cnt_d = scan_cnt + DWELL_W'(1);
      ch_d  = scan_idx;
    end
    mux_idx = (state_d == ST_SCAN) ? scan_idx : sel;
    sel_ok  = 32'(sel) < N;
    // Pulse lands in the first output cycle of channel 0 following channel N-1.
    wrap_d  = (state_d == ST_SCAN) && (state_q == ST_SCAN) &&
              (scan_idx == '0) && (out_ch == LAST_CH);
  end

  mux_nto1_comb #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_mux (
    .in_bus (in_bus),
    .idx    (mux_idx),
    .dout   (mux_data)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= (state_d == ST_SCAN) ? ch_d  : '0;
      cnt_q   <= (state_d == ST_SCAN) ? cnt_d : '0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state_d)
        ST_DIRECT: begin
          out_data  <= mux_data;
          out_ch    <= sel;
          out_valid <= sel_ok;
        end
        ST_SCAN: begin
          out_data  <= mux_data;
          out_ch    <= scan_idx;
          out_valid <= 1'b1;
          wrap      <= wrap_d;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Directed bench: a 16-channel and a 12-channel instance share all controls.
module tb_mux_scan_nto1;

  logic         clk;
  logic         rstb;
  logic         en;
  logic         mode;
  logic [3:0]   sel;
  logic [7:0]   dwell;
  logic [127:0] bus_a;
  logic [95:0]  bus_b;
  logic [7:0]   data_a, data_b;
  logic [3:0]   ch_a, ch_b;
  logic         valid_a, valid_b, wrap_a, wrap_b;

  int checks = 0;
  int errors = 0;

  mux_scan_nto1 #(.WIDTH(8), .N(16), .DWELL_W(8)) dut_a (
    .clk(clk), .rstb(rstb), .in_bus(bus_a), .en(en), .mode(mode),
    .sel(sel), .dwell(dwell), .out_data(data_a), .out_ch(ch_a),
    .out_valid(valid_a), .wrap(wrap_a)
  );

  mux_scan_nto1 #(.WIDTH(8), .N(12), .DWELL_W(8)) dut_b (
    .clk(clk), .rstb(rstb), .in_bus(bus_b), .en(en), .mode(mode),
    .sel(sel), .dwell(dwell), .out_data(data_b), .out_ch(ch_b),
    .out_valid(valid_b), .wrap(wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [7:0] d, input logic [3:0] c,
                         input logic v, input logic w);
    check({tag, ".data"},  32'(data_a),  32'(d));
    check({tag, ".ch"},    32'(ch_a),    32'(c));
    check({tag, ".valid"}, 32'(valid_a), 32'(v));
    check({tag, ".wrap"},  32'(wrap_a),  32'(w));
  endtask

  task automatic check_b(input string tag, input logic [7:0] d, input logic [3:0] c,
                         input logic v, input logic w);
    check({tag, ".b_data"},  32'(data_b),  32'(d));
    check({tag, ".b_ch"},    32'(ch_b),    32'(c));
    check({tag, ".b_valid"}, 32'(valid_b), 32'(v));
    check({tag, ".b_wrap"},  32'(wrap_b),  32'(w));
  endtask

  initial begin
    for (int k = 0; k < 16; k++) bus_a[k*8 +: 8] = 8'h10 + 8'(k);
    for (int k = 0; k < 12; k++) bus_b[k*8 +: 8] = 8'h40 + 8'(k);
    rstb = 1'b1; en = 1'b0; mode = 1'b0; sel = 4'd0; dwell = 8'd0;
    #1 rstb = 1'b0;
    #2;
    check_a("reset", 8'h00, 4'd0, 1'b0, 1'b0);
    check_b("reset", 8'h00, 4'd0, 1'b0, 1'b0);
    step();
    @(negedge clk) rstb = 1'b1;
    step(); step();
    check_a("release_idle", 8'h00, 4'd0, 1'b0, 1'b0);

    // DIRECT
    en = 1'b1; mode = 1'b0; sel = 4'd5;
    step();
    check_a("direct5", 8'h15, 4'd5, 1'b1, 1'b0);
    check_b("direct5", 8'h45, 4'd5, 1'b1, 1'b0);
    sel = 4'd15;
    step();
    check_a("direct15", 8'h1F, 4'd15, 1'b1, 1'b0);
    check_b("direct15_oor", 8'h00, 4'd15, 1'b0, 1'b0);

    // SCAN, dwell=0; out_ch was 15 beforehand, entry must not pulse wrap
    mode = 1'b1; dwell = 8'd0;
    for (int i = 0; i < 16; i++) begin
      step();
      check_a($sformatf("scan0_%0d", i), 8'h10 + 8'(i), 4'(i), 1'b1, 1'b0);
    end
    step();
    check_a("scan0_wrap", 8'h10, 4'd0, 1'b1, 1'b1);
    step();
    check_a("scan0_after", 8'h11, 4'd1, 1'b1, 1'b0);

    // en low: hold data, drop valid
    en = 1'b0;
    step();
    check_a("idle_hold", 8'h11, 4'd1, 1'b0, 1'b0);

    // SCAN, dwell=2: 48-cycle sweep
    en = 1'b1; mode = 1'b1; dwell = 8'd2;
    for (int i = 0; i < 48; i++) begin
      step();
      check_a($sformatf("scan2_%0d", i), 8'h10 + 8'(i / 3), 4'(i / 3), 1'b1, 1'b0);
    end
    step();
    check_a("scan2_wrap", 8'h10, 4'd0, 1'b1, 1'b1);
    dwell = 8'd0;
    step();
    check_a("dwell_cut", 8'h10, 4'd0, 1'b1, 1'b0);
    step();
    check_a("dwell_adv1", 8'h11, 4'd1, 1'b1, 1'b0);
    for (int i = 2; i <= 7; i++) step();
    check_a("scan_ch7", 8'h17, 4'd7, 1'b1, 1'b0);

    // SCAN -> DIRECT -> IDLE -> SCAN restart
    mode = 1'b0; sel = 4'd3;
    step();
    check_a("to_direct", 8'h13, 4'd3, 1'b1, 1'b0);
    en = 1'b0;
    step();
    check_a("to_idle", 8'h13, 4'd3, 1'b0, 1'b0);
    en = 1'b1; mode = 1'b1;
    step();
    check_a("rescan", 8'h10, 4'd0, 1'b1, 1'b0);
    step();
    check_a("rescan1", 8'h11, 4'd1, 1'b1, 1'b0);

    // N=12 sweep: wraps 11 -> 0, never shows 12..15
    en = 1'b0;
    step();
    en = 1'b1; mode = 1'b1; dwell = 8'd0;
    for (int i = 0; i < 12; i++) begin
      step();
      check_b($sformatf("n12_%0d", i), 8'h40 + 8'(i), 4'(i), 1'b1, 1'b0);
    end
    step();
    check_b("n12_wrap", 8'h40, 4'd0, 1'b1, 1'b1);
    check_a("n16_ch12", 8'h1C, 4'd12, 1'b1, 1'b0);

    mode = 1'b0; sel = 4'd13;
    step();
    check_b("n12_sel13", 8'h00, 4'd13, 1'b0, 1'b0);
    check_a("n16_sel13", 8'h1D, 4'd13, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle during a scan
    mode = 1'b1;
    step(); step(); step();
    #3 rstb = 1'b0;
    #1;
    check_a("async_rst", 8'h00, 4'd0, 1'b0, 1'b0);
    check_b("async_rst", 8'h00, 4'd0, 1'b0, 1'b0);
    en = 1'b0;
    @(negedge clk) rstb = 1'b1;
    step(); step();
    check_a("post_rst_idle", 8'h00, 4'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
